x86_exec_unit: RTL and testbench

X86_EXEC_UNIT -- requirements
Module: x86_exec_unit

---
 rtl/x86_pkg.sv | 62 ++++++
 rtl/x86_alu8.sv | 46 ++++
 rtl/x86_exec_unit.sv | 177 +++++++++++++++++
 tb/tb_x86_exec_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/x86_pkg.sv
// Shared types and constants for the 8-bit x86-style execution unit.
package x86_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_W     = 2;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned FLAG_W    = 4;
  localparam int unsigned MUL_CNT_W = 3;
  localparam int unsigned PROD_W    = 2 * DATA_W;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_MOV = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_e;

  localparam logic [REG_W-1:0] REG_AX = 2'd0;
  localparam logic [REG_W-1:0] REG_BX = 2'd1;
  localparam logic [REG_W-1:0] REG_CX = 2'd2;
  localparam logic [REG_W-1:0] REG_DX = 2'd3;

  // Bit positions inside the {Z,S,C,O} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_O = 0;

  typedef struct packed {
    opcode_e           op;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  src;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // One-hot {cx,bx,ax} write enable; DX is read-only.
  function automatic logic [2:0] dst_we(input logic [REG_W-1:0] dst);
    logic [2:0] we;
    we = 3'b000;
    case (dst)
      REG_AX:  we = 3'b001;
      REG_BX:  we = 3'b010;
      REG_CX:  we = 3'b100;
      default: we = 3'b000;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/x86_alu8.sv
// Single-cycle 8-bit ALU: MOV/ADD/SUB/AND/OR/XOR with {Z,S,C,O} flags.
module x86_alu8
  import x86_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic [FLAG_W-1:0] flags
);

  logic [DATA_W:0] r9;
  logic            ovf;

  always_comb begin
    r9  = '0;
    ovf = 1'b0;
    case (opcode_e'(op))
      OP_MOV: r9 = {1'b0, b};
      OP_ADD: begin
        r9  = {1'b0, a} + {1'b0, b};
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r9[DATA_W-1] != a[DATA_W-1]);
      end
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB: begin
        r9  = {1'b0, a} - {1'b0, b};
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (r9[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r9 = {1'b0, a & b};
      OP_OR:   r9 = {1'b0, a | b};
      OP_XOR:  r9 = {1'b0, a ^ b};
      default: r9 = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (r9[DATA_W-1:0] == '0);
    flags[FLAG_S] = r9[DATA_W-1];
    flags[FLAG_C] = r9[DATA_W];
    flags[FLAG_O] = ovf;
  end

  assign res = r9[DATA_W-1:0];

endmodule

// File: rtl/x86_exec_unit.sv
// Multi-cycle execution unit: latch instruction, read operands, execute
// (ALU or 8-step shift-add MUL), then write back for one cycle.
module x86_exec_unit
  import x86_pkg::*;
#(
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  dst,
  input  logic [REG_W-1:0]  src,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  output logic [2:0]        rd_addr1,
  output logic [2:0]        rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] wr_data,
  output logic              we_ax,
  output logic              we_bx,
  output logic              we_cx,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  state_e                 state_q, state_n;
  instr_t                 ins_q, ins_n;
  logic [DATA_W-1:0]      a_q, a_n, b_q, b_n;
  logic [PROD_W-1:0]      mcand_q, mcand_n, acc_q, acc_n;
  logic [DATA_W-1:0]      mplier_q, mplier_n;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_n;
  logic [DATA_W-1:0]      wr_data_n;
  logic [2:0]             we_n;
  logic [FLAG_W-1:0]      flags_n;
  logic                   ready_n, busy_n;

  logic [DATA_W-1:0]      alu_res;
  logic [FLAG_W-1:0]      alu_flags;
  logic [PROD_W-1:0]      prod;
  logic                   wb_go;
  logic [DATA_W-1:0]      wb_val;
  logic [FLAG_W-1:0]      wb_flags;
  opcode_e                op_in;

  x86_alu8 u_alu (
    .op    (ins_q.op),
    .a     (a_q),
    .b     (b_q),
    .res   (alu_res),
    .flags (alu_flags)
  );

  assign rd_addr1 = {1'b0, ins_q.dst};
  assign rd_addr2 = {1'b0, ins_q.src};

  // With the multiplier disabled, MUL is downgraded to NOP at accept time.
  assign op_in = (opcode_e'(opcode) == OP_MUL && !ENABLE_MUL) ? OP_NOP : opcode_e'(opcode);

  always_comb begin
    state_n   = state_q;
    ins_n     = ins_q;
    a_n       = a_q;
    b_n       = b_q;
    mcand_n   = mcand_q;
    mplier_n  = mplier_q;
    acc_n     = acc_q;
    cnt_n     = cnt_q;
    flags_n   = flags;
    wr_data_n = '0;
    we_n      = 3'b000;
    wb_go     = 1'b0;
    wb_val    = '0;
    wb_flags  = '0;
    prod      = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          ins_n.op      = op_in;
          ins_n.dst     = dst;
          ins_n.src     = src;
          ins_n.imm_sel = imm_sel;
          ins_n.imm     = imm;
          state_n       = S_READ;
        end
      end
      S_READ: begin
        a_n     = rd_data1;
        b_n     = ins_q.imm_sel ? ins_q.imm : rd_data2;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        if (ins_q.op == OP_MUL) begin
          mcand_n  = PROD_W'(a_q);
          mplier_n = b_q;
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = S_MUL;
        end else begin
          wb_go    = 1'b1;
          wb_val   = alu_res;
          wb_flags = alu_flags;
          state_n  = S_WB;
        end
      end
      // One multiplier bit per cycle; the 8th step feeds write-back directly.
      S_MUL: begin
        acc_n    = prod;
        mcand_n  = mcand_q << 1;
        mplier_n = mplier_q >> 1;
        cnt_n    = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == MUL_CNT_W'(7)) begin
          wb_go            = 1'b1;
          wb_val           = prod[DATA_W-1:0];
          wb_flags[FLAG_Z] = (prod[DATA_W-1:0] == '0);
          wb_flags[FLAG_S] = prod[DATA_W-1];
          wb_flags[FLAG_C] = |prod[PROD_W-1:DATA_W];
          wb_flags[FLAG_O] = |prod[PROD_W-1:DATA_W];
          state_n          = S_WB;
        end
      end
      S_WB:    state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (wb_go) begin
      wr_data_n = wb_val;
      if (ins_q.op != OP_NOP) begin
        flags_n = wb_flags;
        we_n    = dst_we(ins_q.dst);
      end
    end

    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ins_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wr_data     <= '0;
      we_ax       <= 1'b0;
      we_bx       <= 1'b0;
      we_cx       <= 1'b0;
      flags       <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      ins_q       <= ins_n;
      a_q         <= a_n;
      b_q         <= b_n;
      mcand_q     <= mcand_n;
      mplier_q    <= mplier_n;
      acc_q       <= acc_n;
      cnt_q       <= cnt_n;
      wr_data     <= wr_data_n;
      we_ax       <= we_n[0];
      we_bx       <= we_n[1];
      we_cx       <= we_n[2];
      flags       <= flags_n;
      instr_ready <= ready_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_x86_exec_unit.sv
// Directed bench for x86_exec_unit: vector table plus mid-MUL reset sequence.
module tb_x86_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [1:0] dst, src;
  logic       imm_sel;
  logic [7:0] imm;
  logic [2:0] rd_addr1, rd_addr2;
  logic [7:0] rd_data1, rd_data2;
  logic [7:0] wr_data;
  logic       we_ax, we_bx, we_cx;
  logic [3:0] flags;
  logic       busy;

  logic [7:0] rf [4];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic       imm_sel;
    logic [7:0] imm;
    logic [7:0] exp_data;
    logic [2:0] exp_we;
    logic [3:0] exp_flags;
    int         exp_lat;
  } vec_t;

  vec_t vecs [14];

  x86_exec_unit #(.ENABLE_MUL(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dst(dst), .src(src), .imm_sel(imm_sel), .imm(imm),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_data(wr_data), .we_ax(we_ax), .we_bx(we_bx), .we_cx(we_cx),
    .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, DX fixed.
  always_comb begin
    rd_data1 = (rd_addr1[2] == 1'b0) ? rf[rd_addr1[1:0]] : 8'h00;
    rd_data2 = (rd_addr2[2] == 1'b0) ? rf[rd_addr2[1:0]] : 8'h00;
  end

  always @(posedge clk) begin
    if (we_ax) rf[0] <= wr_data;
    if (we_bx) rf[1] <= wr_data;
    if (we_cx) rf[2] <= wr_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k, first_we, we_cnt, ready_k;
    logic [7:0] got_data;
    logic [2:0] got_we;
    first_we = 0; we_cnt = 0; ready_k = 0; got_data = '0; got_we = '0;
    @(negedge clk);
    chk({nm, "_ready_idle"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; opcode = v.op; dst = v.dst; src = v.src;
    imm_sel = v.imm_sel; imm = v.imm;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    k = 1;
    while (k <= 20) begin
      if (we_ax || we_bx || we_cx) begin
        we_cnt++;
        if (first_we == 0) begin
          first_we = k; got_data = wr_data; got_we = {we_cx, we_bx, we_ax};
        end
      end
      if (instr_ready) begin
        ready_k = k;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_ready_return"}, 32'(ready_k), 32'(v.exp_lat + 1));
    chk({nm, "_we_count"}, 32'(we_cnt), (v.exp_we != 3'b000) ? 32'd1 : 32'd0);
    if (v.exp_we != 3'b000) begin
      chk({nm, "_we_latency"}, 32'(first_we), 32'(v.exp_lat));
      chk({nm, "_we_onehot"}, 32'(got_we), 32'(v.exp_we));
      chk({nm, "_wr_data"}, 32'(got_data), 32'(v.exp_data));
    end
    chk({nm, "_flags"}, 32'(flags), 32'(v.exp_flags));
  endtask

  initial begin
    int we_seen;
    vec_t mov11;
    rf[0] = 8'h00; rf[1] = 8'h00; rf[2] = 8'h00; rf[3] = 8'h33;
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; dst = '0; src = '0;
    imm_sel = 1'b0; imm = '0;

    //            op  dst src sel imm    data   we      {Z,S,C,O} lat
    vecs[0]  = '{3'd1, 2'd0, 2'd0, 1'b1, 8'h5A, 8'h5A, 3'b001, 4'b0000, 3};
    vecs[1]  = '{3'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 3'b001, 4'b0000, 3};
    vecs[2]  = '{3'd2, 2'd0, 2'd0, 1'b1, 8'h01, 8'h80, 3'b001, 4'b0101, 3};
    vecs[3]  = '{3'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 3'b010, 4'b1000, 3};
    vecs[4]  = '{3'd3, 2'd1, 2'd0, 1'b1, 8'h01, 8'hFF, 3'b010, 4'b0110, 3};
    vecs[5]  = '{3'd1, 2'd2, 2'd0, 1'b1, 8'h10, 8'h10, 3'b100, 4'b0000, 3};
    vecs[6]  = '{3'd7, 2'd2, 2'd0, 1'b1, 8'h20, 8'h00, 3'b100, 4'b1011, 11};
    vecs[7]  = '{3'd6, 2'd3, 2'd0, 1'b1, 8'hFF, 8'hCC, 3'b000, 4'b0100, 3};
    vecs[8]  = '{3'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 3'b001, 4'b1011, 3};
    vecs[9]  = '{3'd5, 2'd2, 2'd1, 1'b0, 8'h00, 8'hFF, 3'b100, 4'b0100, 3};
    vecs[10] = '{3'd0, 2'd0, 2'd0, 1'b1, 8'h55, 8'h00, 3'b000, 4'b0100, 3};
    vecs[11] = '{3'd4, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h0F, 3'b010, 4'b0000, 3};
    vecs[12] = '{3'd7, 2'd1, 2'd0, 1'b1, 8'h0D, 8'hC3, 3'b010, 4'b0100, 11};
    vecs[13] = '{3'd3, 2'd0, 2'd0, 1'b1, 8'h80, 8'h80, 3'b001, 4'b0111, 3};
    mov11    = '{3'd1, 2'd0, 2'd0, 1'b1, 8'h11, 8'h11, 3'b001, 4'b0000, 3};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_we", 32'({we_cx, we_bx, we_ax}), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in MUL iteration 4: MUL AX(0x80), imm 0x03.
    we_seen = 0;
    @(negedge clk);
    instr_valid = 1'b1; opcode = 3'd7; dst = 2'd0; src = 2'd0; imm_sel = 1'b1; imm = 8'h03;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      if (we_ax || we_bx || we_cx) we_seen++;
      @(posedge clk); #1;
    end
    chk("mulrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mulrst_ready", 32'(instr_ready), 32'd1);
    chk("mulrst_busy", 32'(busy), 32'd0);
    chk("mulrst_flags", 32'(flags), 32'd0);
    chk("mulrst_wr_data", 32'(wr_data), 32'd0);
    for (int k = 0; k < 15; k++) begin
      if (we_ax || we_bx || we_cx) we_seen++;
      @(posedge clk); #1;
    end
    chk("mulrst_no_write", 32'(we_seen), 32'd0);
    chk("mulrst_ax_kept", 32'(rf[0]), 32'h80);
    run_vec(mov11, "post_rst_mov");
    chk("post_rst_ax", 32'(rf[0]), 32'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
